// File: rtl/pipe_sched.sv
// pipe_sched: pipeline sequencing controller for the 5-stage core.
//
// Merges the ID load-use stall request, multi-cycle MDU occupancy of EX and
// MEM-stage exception redirects into one per-stage stall bus plus a
// flush/new-PC redirect.
//
// Parameters
//   MUL_LAT  total EX occupancy of a multiply in cycles (>= 2)
//   DIV_LAT  total EX occupancy of a divide in cycles (>= 2)
//   CNT_W    occupancy counter width, must hold DIV_LAT-2
//
// Ports
//   clk                single clock, rising edge
//   rst_n              asynchronous active-low reset
//   stallreq_for_load  ID load-use hazard request (level)
//   ex_mdu_req         EX holds a mul/div instruction (level)
//   ex_mdu_is_div      1 = divide, 0 = multiply (qualifies ex_mdu_req)
//   excp_req           MEM exception/eret redirect request (1-cycle pulse)
//   excp_vector        redirect target, valid with excp_req
//   stall              bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   flush              kill IF/ID/EX contents this cycle
//   new_pc             redirect PC when flush=1, else 0
//   mdu_busy           registered: controller is in BUSY
//   mdu_done           last MDU cycle, EX result valid and EX advances
//   stall_cnt          saturating count of cycles with stall[0]=1
//
// Handshake: there is no valid/ready pair here. ex_mdu_req is a level held by
// EX while it is stalled; the cycle mdu_done=1 is the one in which EX advances,
// so a request still present the cycle after that belongs to the next op.

module pipe_sched #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_for_load,
  input  logic        ex_mdu_req,
  input  logic        ex_mdu_is_div,
  input  logic        excp_req,
  input  logic [31:0] excp_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LOAD = 6'b000111;  // PC, IF, ID
  localparam logic [5:0] STALL_MDU  = 6'b001111;  // PC, IF, ID, EX

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             mdu_busy_q;
  logic [31:0]      stall_cnt_q;

  logic [5:0]  stall_d;
  logic        flush_d;
  logic [31:0] new_pc_d;
  logic        done_d;

  // Next state and combinational outputs. Exception beats everything; in BUSY
  // the load request and the held MDU request are frozen with ID/EX.
  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    stall_d  = STALL_NONE;
    flush_d  = 1'b0;
    new_pc_d = 32'h0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (excp_req) begin
          flush_d  = 1'b1;
          new_pc_d = excp_vector;
        end else if (ex_mdu_req) begin
          stall_d = STALL_MDU;
          occ_d   = ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
          state_d = BUSY;
        end else if (stallreq_for_load) begin
          stall_d = STALL_LOAD;
        end
      end
      BUSY: begin
        if (excp_req) begin
          flush_d  = 1'b1;
          new_pc_d = excp_vector;
          occ_d    = '0;
          state_d  = IDLE;
        end else if (occ_q != '0) begin
          stall_d = STALL_MDU;
          occ_d   = occ_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        occ_d   = '0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      mdu_busy_q  <= 1'b0;
      stall_cnt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      mdu_busy_q <= (state_d == BUSY);
      if (stall_d[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // Combinational outputs are forced quiet while reset is held so the
  // pipeline never sees a stall or redirect derived from live inputs.
  assign stall     = rst_n ? stall_d  : STALL_NONE;
  assign flush     = rst_n & flush_d;
  assign new_pc    = rst_n ? new_pc_d : 32'h0;
  assign mdu_done  = rst_n & done_d;
  assign mdu_busy  = mdu_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed testbench for pipe_sched: reset, load-use, multiply, divide with
// concurrent load request, abort, exception priority, back-to-back ops,
// reset mid-op and stall counter saturation.

module tb_pipe_sched;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_for_load;
  logic        ex_mdu_req;
  logic        ex_mdu_is_div;
  logic        excp_req;
  logic [31:0] excp_vector;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_sched #(.MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stallreq_for_load(stallreq_for_load),
    .ex_mdu_req       (ex_mdu_req),
    .ex_mdu_is_div    (ex_mdu_is_div),
    .excp_req         (excp_req),
    .excp_vector      (excp_vector),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .mdu_busy         (mdu_busy),
    .mdu_done         (mdu_done),
    .stall_cnt        (stall_cnt)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  // All stimulus changes happen 1 time unit after a rising edge; combinational
  // outputs are checked after a further settle delay, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_for_load = 1'b0;
    ex_mdu_req        = 1'b0;
    ex_mdu_is_div     = 1'b0;
    excp_req          = 1'b0;
    excp_vector       = 32'h0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset with every input high: all outputs must be quiet.
    rst_n             = 1'b0;
    stallreq_for_load = 1'b1;
    ex_mdu_req        = 1'b1;
    ex_mdu_is_div     = 1'b1;
    excp_req          = 1'b1;
    excp_vector       = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("rst_stall",  32'(stall),    32'h0);
    chk("rst_flush",  32'(flush),    32'h0);
    chk("rst_new_pc", new_pc,        32'h0);
    chk("rst_done",   32'(mdu_done), 32'h0);
    chk("rst_busy",   32'(mdu_busy), 32'h0);
    chk("rst_cnt",    stall_cnt,     32'h0);
    idle_inputs();
    settle();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy",  32'(mdu_busy), 32'h0);
    chk("post_rst_stall", 32'(stall),    32'h0);

    // Load-use for two cycles.
    stallreq_for_load = 1'b1;
    settle();
    chk("load_stall0", 32'(stall), 32'h07);
    chk("load_flush",  32'(flush), 32'h0);
    tick();
    chk("load_stall1", 32'(stall), 32'h07);
    tick();
    stallreq_for_load = 1'b0;
    settle();
    chk("load_cnt",   stall_cnt,  32'd2);
    chk("load_clear", 32'(stall), 32'h0);

    // Multiply: stall one cycle, done the next.
    ex_mdu_req    = 1'b1;
    ex_mdu_is_div = 1'b0;
    settle();
    chk("mul_stall_T", 32'(stall),    32'h0F);
    chk("mul_done_T",  32'(mdu_done), 32'h0);
    chk("mul_busy_T",  32'(mdu_busy), 32'h0);
    tick();
    chk("mul_busy_T1",  32'(mdu_busy), 32'h1);
    chk("mul_done_T1",  32'(mdu_done), 32'h1);
    chk("mul_stall_T1", 32'(stall),    32'h0);
    ex_mdu_req = 1'b0;
    tick();
    chk("mul_idle",  32'(mdu_busy), 32'h0);
    chk("mul_cnt",   stall_cnt,     32'd3);

    // Divide with load-use request held throughout: 32 stall cycles.
    ex_mdu_req        = 1'b1;
    ex_mdu_is_div     = 1'b1;
    stallreq_for_load = 1'b1;
    settle();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("div_stall_%0d", i), 32'(stall), 32'h0F);
      chk($sformatf("div_nodone_%0d", i), 32'(mdu_done), 32'h0);
      tick();
    end
    chk("div_done",  32'(mdu_done), 32'h1);
    chk("div_stall", 32'(stall),    32'h0);
    chk("div_busy",  32'(mdu_busy), 32'h1);
    chk("div_cnt",   stall_cnt,     32'd35);
    idle_inputs();
    tick();
    chk("div_idle", 32'(mdu_busy), 32'h0);

    // Abort a divide with an exception at T+10.
    ex_mdu_req    = 1'b1;
    ex_mdu_is_div = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("abort_stall_%0d", i), 32'(stall), 32'h0F);
      tick();
    end
    excp_req    = 1'b1;
    excp_vector = 32'hBFC0_0380;
    settle();
    chk("abort_flush",  32'(flush),    32'h1);
    chk("abort_new_pc", new_pc,        32'hBFC0_0380);
    chk("abort_stall",  32'(stall),    32'h0);
    chk("abort_done",   32'(mdu_done), 32'h0);
    tick();
    idle_inputs();
    settle();
    chk("abort_idle",   32'(mdu_busy), 32'h0);
    chk("abort_noflush", 32'(flush),   32'h0);
    chk("abort_pc0",    new_pc,        32'h0);
    chk("abort_cnt",    stall_cnt,     32'd45);

    // Exception in IDLE together with MDU and load requests: flush wins.
    ex_mdu_req        = 1'b1;
    stallreq_for_load = 1'b1;
    excp_req          = 1'b1;
    excp_vector       = 32'h1234_5678;
    settle();
    chk("ex_idle_flush",  32'(flush), 32'h1);
    chk("ex_idle_pc",     new_pc,     32'h1234_5678);
    chk("ex_idle_stall",  32'(stall), 32'h0);
    tick();
    idle_inputs();
    chk("ex_idle_nobusy", 32'(mdu_busy), 32'h0);
    chk("ex_idle_cnt",    stall_cnt,     32'd45);

    // Exception on the mdu_done cycle: flush wins, no done.
    ex_mdu_req = 1'b1;
    tick();
    excp_req    = 1'b1;
    excp_vector = 32'h8000_0180;
    settle();
    chk("ex_done_flush", 32'(flush),    32'h1);
    chk("ex_done_done",  32'(mdu_done), 32'h0);
    chk("ex_done_stall", 32'(stall),    32'h0);
    tick();
    idle_inputs();
    chk("ex_done_idle", 32'(mdu_busy), 32'h0);
    chk("ex_done_cnt",  stall_cnt,     32'd46);

    // Back-to-back multiplies with the request held: second op starts at T+2.
    ex_mdu_req = 1'b1;
    tick();
    chk("b2b_done1", 32'(mdu_done), 32'h1);
    tick();
    chk("b2b_stall2", 32'(stall),    32'h0F);
    chk("b2b_busy2",  32'(mdu_busy), 32'h0);
    tick();
    chk("b2b_done2", 32'(mdu_done), 32'h1);
    chk("b2b_busy3", 32'(mdu_busy), 32'h1);
    ex_mdu_req = 1'b0;
    tick();
    chk("b2b_idle", 32'(mdu_busy), 32'h0);
    chk("b2b_cnt",  stall_cnt,     32'd48);

    // Reset in the middle of a divide: nothing persists.
    ex_mdu_req    = 1'b1;
    ex_mdu_is_div = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    settle();
    chk("mid_rst_busy",  32'(mdu_busy), 32'h0);
    chk("mid_rst_stall", 32'(stall),    32'h0);
    chk("mid_rst_cnt",   stall_cnt,     32'h0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle",  32'(mdu_busy), 32'h0);
    chk("mid_rst_quiet", 32'(stall),    32'h0);

    // Saturation of the stall counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    settle();
    release dut.stall_cnt_q;
    stallreq_for_load = 1'b1;
    tick();
    chk("sat_cnt0", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_cnt1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_cnt2", stall_cnt, 32'hFFFF_FFFF);
    stallreq_for_load = 1'b0;
    tick();

    // ---------------------------------------------------------------- report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
